mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and access sequencer for the shared data RAM. It sits between the core's data-access port (requester 0) and the program loader/debug port (requester 1) on one side, and one read port plus the single write port of `mem` on the other. It serialises requests with round-robin fairness and drives exactly one RAM access per grant. It returns read data and completion through a registered response.

## Interface

- `ADDR_W`, 8: word-address width; equals the RAM size log2.
- `clk`  in  1  system clock; all state updates on the rising edge. RAM writes commit on the falling edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request. Hold it high, with command fields stable, until the matching `gnt` is sampled.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `mode0`, `mode1`  in  3  access mode: 000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
- `addr0`, `addr1`  in  ADDR_W  word address.
- `wdata0`, `wdata1`  in  32  write data.
- `gnt0`, `gnt1`  out  1  command accepted this cycle (combinational, one-cycle pulse).
- `rvalid0`, `rvalid1`  out  1  completion pulse (reads and writes).
- `rerr0`, `rerr1`  out  1  illegal mode for the access; valid with `rvalid`.
- `rdata0`, `rdata1`  out  32  read data; valid with `rvalid`.
- `mem_ra`, `mem_wa`  out  ADDR_W  RAM read / write address.
- `mem_rm`, `mem_wm`  out  3  RAM read / write mode.
- `mem_we`  out  1  RAM write enable.
- `mem_wd`  out  32  RAM write data.
- `mem_rd`  in  32  RAM read data; combinational from `mem_ra`/`mem_rm`.

## Operation

- FSM states:
  - IDLE: no access.
  - ACCESS: RAM driven from the command register.
  - RESP: response presented.
- Grants are allowed only when the state is IDLE or RESP.
- Winner selection:
  - Only one `req` high → that requester wins.
  - Both high → the requester not named by `last` wins.
  - `last` updates to the winner on every grant.
  - Reset value of `last` is 1, so requester 0 wins the first tie.
- On grant:
  - Latch `{id, we, mode, addr, wdata}` into the command register.
  - Go to ACCESS.
  - RESP with no grant → IDLE.
- ACCESS:
  - Drive `mem_ra`/`mem_wa` = cmd addr, `mem_rm`/`mem_wm` = cmd mode, `mem_wd` = cmd wdata.
  - Write: `mem_we` = 1 only if mode ∈ {000, 001, 010}. Otherwise `mem_we` stays 0 and the error flag is set.
  - Read: mode ∈ {000, 001, 010, 100, 101} is legal. On an illegal mode, capture data as 0 and set the error flag.
  - At the end of the cycle, capture `mem_rd` (read) or 0 (write) into the response register. Go to RESP.
- RESP:
  - `rvalid<id>` = 1; `rdata<id>` and `rerr<id>` come from the response register.
  - The other requester's response outputs stay 0.
- Outside ACCESS: `mem_we` = 0. Address, mode and data outputs hold their last values; all are 0 after reset.
- A write followed by a read of the same address returns the new data. The write commits at the falling edge of its ACCESS cycle, before the read's ACCESS cycle.

## Timing

- Reset values: state IDLE, `last` = 1, command and response registers 0. All outputs are 0: `gnt*`, `rvalid*`, `rerr*`, `rdata*`, `mem_*`.
- Asserting `rst_n` low in ACCESS drops `mem_we` immediately.
  - If low before the falling edge, the write is aborted.
  - No `rvalid` is issued for the aborted command.
- Latency, with grant in cycle t:
  - RAM access in t+1.
  - `rvalid` in t+2.
- Back-to-back: a new grant may coincide with RESP (cycle t+2), so peak throughput is one access per 2 cycles.
- Requests arriving during ACCESS wait; `gnt` stays 0 in ACCESS.
- `gnt` depends combinationally on `req*`, state and `last`, with no path from the `mem_*` inputs.
- `req` dropped before grant is simply withdrawn; there is no penalty.
- `req` still high the cycle after `gnt` counts as a new request.

## Test plan

- Reset, then `req0` write, word mode, `addr0` = 5, `wdata0` = 0xDEADBEEF → `gnt0` in t. In t+1, `mem_we` = 1, `mem_wa` = 5, `mem_wd` = 0xDEADBEEF. In t+2, `rvalid0` = 1, `rerr0` = 0.
- `req1` read, mode 000, addr 5 (RAM holds 0x000000F0) → `rvalid1` at t+2 with `rdata1` = 0xFFFFFFF0. Repeat with mode 100 → `rdata1` = 0x000000F0.
- `req0` and `req1` held high continuously from reset → grant order 0, 1, 0, 1, with grants every 2 cycles. `rvalid` ids match the grant order.
- Write with mode 100 → `mem_we` never asserts and `rvalid` comes with `rerr` = 1. Read with mode 011 → `rdata` = 0, `rerr` = 1.
- Write grant, then `rst_n` pulsed low during ACCESS before the falling edge → RAM word unchanged, no `rvalid`. All outputs are 0 while reset is low.
- Write 0x12345678 to addr 9 via requester 1, then immediately a requester 0 read of addr 9, mode 010 → `rdata0` = 0x12345678.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared data RAM.
// slave = arbiter view, master = environment (requesters + RAM) view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              req0, req1;
  logic              we0, we1;
  logic [2:0]        mode0, mode1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic              rerr0, rerr1;
  logic [31:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] mem_ra, mem_wa;
  logic [2:0]        mem_rm, mem_wm;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  modport slave (
    input  req0, req1, we0, we1, mode0, mode1, addr0, addr1, wdata0, wdata1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
           mem_ra, mem_wa, mem_rm, mem_wm, mem_we, mem_wd
  );

  modport master (
    output req0, req1, we0, we1, mode0, mode1, addr0, addr1, wdata0, wdata1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
           mem_ra, mem_wa, mem_rm, mem_wm, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing one RAM read port and write port.
// One access per grant: grant (t), RAM access (t+1), registered response (t+2).
module mem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              cmd_id_q, cmd_id_d;
  logic              cmd_we_q, cmd_we_d;
  logic [2:0]        cmd_mode_q, cmd_mode_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic              gnt0_c, gnt1_c, win;
  logic              legal_wr, legal_rd;
  logic              rvalid0_c, rvalid1_c;

  assign legal_wr = (cmd_mode_q == 3'b000) || (cmd_mode_q == 3'b001) || (cmd_mode_q == 3'b010);
  assign legal_rd = legal_wr || (cmd_mode_q == 3'b100) || (cmd_mode_q == 3'b101);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cmd_id_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_mode_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_id_q    <= cmd_id_d;
      cmd_we_q    <= cmd_we_d;
      cmd_mode_q  <= cmd_mode_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_id_d    = cmd_id_q;
    cmd_we_d    = cmd_we_q;
    cmd_mode_d  = cmd_mode_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;
    win         = 1'b0;

    // On a tie the requester that did not win last time goes next.
    if ((state_q == IDLE || state_q == RESP) && (bus.req0 || bus.req1)) begin
      win    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
      gnt0_c = ~win;
      gnt1_c = win;
      last_d      = win;
      cmd_id_d    = win;
      cmd_we_d    = win ? bus.we1    : bus.we0;
      cmd_mode_d  = win ? bus.mode1  : bus.mode0;
      cmd_addr_d  = win ? bus.addr1  : bus.addr0;
      cmd_wdata_d = win ? bus.wdata1 : bus.wdata0;
    end

    case (state_q)
      IDLE: begin
        if (gnt0_c || gnt1_c) state_d = ACCESS;
      end
      ACCESS: begin
        if (cmd_we_q) begin
          resp_data_d = '0;
          resp_err_d  = ~legal_wr;
        end else begin
          resp_data_d = legal_rd ? bus.mem_rd : '0;
          resp_err_d  = ~legal_rd;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = (gnt0_c || gnt1_c) ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rvalid0_c = (state_q == RESP) && !cmd_id_q;
  assign rvalid1_c = (state_q == RESP) &&  cmd_id_q;

  // Grants are combinational from req, so mask them while reset is held.
  assign bus.gnt0    = gnt0_c & rst_n;
  assign bus.gnt1    = gnt1_c & rst_n;
  assign bus.rvalid0 = rvalid0_c;
  assign bus.rvalid1 = rvalid1_c;
  assign bus.rerr0   = rvalid0_c & resp_err_q;
  assign bus.rerr1   = rvalid1_c & resp_err_q;
  assign bus.rdata0  = rvalid0_c ? resp_data_q : '0;
  assign bus.rdata1  = rvalid1_c ? resp_data_q : '0;

  // The command register only changes on entry to ACCESS, so the RAM side holds between accesses.
  assign bus.mem_ra  = cmd_addr_q;
  assign bus.mem_wa  = cmd_addr_q;
  assign bus.mem_rm  = cmd_mode_q;
  assign bus.mem_wm  = cmd_mode_q;
  assign bus.mem_wd  = cmd_wdata_q;
  assign bus.mem_we  = (state_q == ACCESS) && cmd_we_q && legal_wr;

endmodule
